gpr_wb_arbiter: RTL

// Write-side master of the GPR write port (RD/RegWrite/WData). Merges results from ALU (fixed

---
 rtl/gpr_wb_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/gpr_wb_arbiter.sv
// ============================================================================
// gpr_wb_arbiter : single GPR write port arbiter (ALU > load FIFO > mul/div)
// Revision 1.0
// ============================================================================
`default_nettype none

module gpr_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         AluValid,
  input  logic [4:0]   AluRD,
  input  logic [W-1:0] AluData,
  input  logic         LdValid,
  input  logic [4:0]   LdRD,
  input  logic [W-1:0] LdData,
  output logic         LdReady,
  input  logic         MdValid,
  input  logic [4:0]   MdRD,
  input  logic [W-1:0] MdData,
  output logic         MdReady,
  output logic [4:0]   RD,
  output logic         RegWrite,
  output logic [W-1:0] WData,
  output logic [31:0]  Pending
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  // Load FIFO storage; live bits are also cleared on pop so unused slots stay dead.
  logic [W-1:0]     fdata_q [DEPTH];
  logic [W-1:0]     fdata_d [DEPTH];
  logic [4:0]       frd_q   [DEPTH];
  logic [4:0]       frd_d   [DEPTH];
  logic [DEPTH-1:0] flive_q, flive_d;
  logic [AW-1:0]    wrp_q, wrp_d;
  logic [AW-1:0]    rdp_q, rdp_d;
  logic [AW:0]      cnt_q, cnt_d;

  logic             hv_q, hv_d;
  logic             hlive_q, hlive_d;
  logic [4:0]       hrd_q, hrd_d;
  logic [W-1:0]     hdata_q, hdata_d;

  logic [4:0]       rd_q, rd_d;
  logic             we_q, we_d;
  logic [W-1:0]     wd_q, wd_d;

  logic sq, push, md_acc, pop_f, pop_h;

  assign LdReady = (cnt_q < C_FULL);
  assign MdReady = !hv_q;

  assign sq     = AluValid && (AluRD != 5'd0);
  assign push   = LdValid && LdReady;
  assign md_acc = MdValid && MdReady;
  assign pop_f  = !AluValid && (cnt_q != '0);
  assign pop_h  = !AluValid && (cnt_q == '0) && hv_q;

  assign RD       = rd_q;
  assign RegWrite = we_q;
  assign WData    = wd_q;

  always_comb begin
    fdata_d = fdata_q;
    frd_d   = frd_q;
    flive_d = flive_q;
    wrp_d   = wrp_q;
    rdp_d   = rdp_q;
    cnt_d   = cnt_q;
    hv_d    = hv_q;
    hlive_d = hlive_q;
    hrd_d   = hrd_q;
    hdata_d = hdata_q;
    rd_d    = rd_q;
    we_d    = 1'b0;
    wd_d    = wd_q;

    // A younger ALU write makes any buffered result to the same register stale.
    if (sq) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (frd_q[i] == AluRD) flive_d[i] = 1'b0;
      end
      if (hrd_q == AluRD) hlive_d = 1'b0;
    end

    if (pop_f) begin
      flive_d[rdp_q] = 1'b0;
      rdp_d          = rdp_q + 1'b1;
    end

    if (push) begin
      fdata_d[wrp_q] = LdData;
      frd_d[wrp_q]   = LdRD;
      flive_d[wrp_q] = !(sq && (LdRD == AluRD));
      wrp_d          = wrp_q + 1'b1;
    end

    unique case ({push, pop_f})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    if (pop_h) begin
      hv_d    = 1'b0;
      hlive_d = 1'b0;
    end
    if (md_acc) begin
      hv_d    = 1'b1;
      hlive_d = !(sq && (MdRD == AluRD));
      hrd_d   = MdRD;
      hdata_d = MdData;
    end

    if (AluValid) begin
      rd_d = AluRD;
      wd_d = AluData;
      we_d = (AluRD != 5'd0);
    end else if (pop_f) begin
      rd_d = frd_q[rdp_q];
      wd_d = fdata_q[rdp_q];
      we_d = flive_q[rdp_q] && (frd_q[rdp_q] != 5'd0);
    end else if (pop_h) begin
      rd_d = hrd_q;
      wd_d = hdata_q;
      we_d = hlive_q && (hrd_q != 5'd0);
    end
  end

  always_comb begin
    Pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (flive_q[i]) Pending[frd_q[i]] = 1'b1;
    end
    if (hlive_q) Pending[hrd_q] = 1'b1;
    Pending[0] = 1'b0;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        fdata_q[i] <= '0;
        frd_q[i]   <= '0;
      end
      flive_q <= '0;
      wrp_q   <= '0;
      rdp_q   <= '0;
      cnt_q   <= '0;
      hv_q    <= 1'b0;
      hlive_q <= 1'b0;
      hrd_q   <= '0;
      hdata_q <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      wd_q    <= '0;
    end else begin
      fdata_q <= fdata_d;
      frd_q   <= frd_d;
      flive_q <= flive_d;
      wrp_q   <= wrp_d;
      rdp_q   <= rdp_d;
      cnt_q   <= cnt_d;
      hv_q    <= hv_d;
      hlive_q <= hlive_d;
      hrd_q   <= hrd_d;
      hdata_q <= hdata_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      wd_q    <= wd_d;
    end
  end

endmodule

`default_nettype wire
